// File: rtl/polar_enc_pkg.sv
// polar_enc_pkg
//   Shared definitions for the serial polar encoder: default maximum code
//   size, counter widths, the FSM state encoding and a small legality helper
//   for the requested block size.
package polar_enc_pkg;

    localparam int N_LOG2_MAX_DEF = 10;
    localparam int IDX_W          = N_LOG2_MAX_DEF;
    localparam int STG_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_XFORM  = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

    // A block size is legal when 1 <= nLog2 <= max_log2.
    function automatic logic nlog2_legal(input logic [STG_W-1:0] nl, input int max_log2);
        return (nl != '0) && (int'(nl) <= max_log2);
    endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// polar_butterfly_stage
//   One combinational stage of the polar transform x = u * G_N.
//   For every position j < N whose bit s is clear:
//       v[j] = u[j] ^ u[j + 2^s]
//   all other positions (bit s set, or j >= N) pass through unchanged.
//
// Ports
//   u_i     : current 2^N_LOG2_MAX-bit working vector
//   s_i     : stage index to apply (only values below N_LOG2_MAX are used)
//   nlog2_i : log2 of the active block length N
//   v_o     : vector after the stage-s update
module polar_butterfly_stage
    import polar_enc_pkg::*;
#(
    parameter int N_LOG2_MAX = N_LOG2_MAX_DEF
) (
    input  logic [(1<<N_LOG2_MAX)-1:0] u_i,
    input  logic [STG_W-1:0]           s_i,
    input  logic [STG_W-1:0]           nlog2_i,
    output logic [(1<<N_LOG2_MAX)-1:0] v_o
);

    localparam int NMAX = 1 << N_LOG2_MAX;
    localparam int IW   = N_LOG2_MAX;

    for (genvar j = 0; j < NMAX; j++) begin : g_pos
        localparam logic [IW-1:0] J_VAL = IW'(j);

        // partner[k] holds u[j + 2^k] when j is the upper-half leg of a
        // stage-k butterfly; otherwise 0 so the XOR is a no-op. Padding to
        // 2^STG_W entries keeps the s_i index in range for every s value.
        logic [(1<<STG_W)-1:0] partner;
        logic                  in_block;

        for (genvar k = 0; k < (1 << STG_W); k++) begin : g_stg
            if (k < N_LOG2_MAX && ((j >> k) & 1) == 0) begin : g_pair
                assign partner[k] = u_i[j + (1 << k)];
            end else begin : g_none
                assign partner[k] = 1'b0;
            end
        end

        assign in_block = ((J_VAL >> nlog2_i) == '0);
        assign v_o[j]   = u_i[j] ^ (partner[s_i] & in_block);
    end

endmodule

// File: rtl/polar_encoder_core.sv
// polar_encoder_core
//   Serial polar encoder for the loopback path into the decoder LLR
//   generator. Collects N u-bits (frozen positions forced to 0), applies
//   the n butterfly stages one per cycle in place, then streams x_0..x_{N-1}
//   out in natural order.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   enb                : clock enable, all state holds while low
//   start, nLog2       : begin a block of N = 2^nLog2 bits (sampled in IDLE)
//   inValid/inReady    : u-bit handshake, with inBit value and F (1 = info)
//   outValid/outReady  : codeword handshake, with outBit and outLast
//   busy               : FSM not in IDLE
//   cfgErr             : one-cycle pulse on start with illegal nLog2
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start; storage cleared on legal start
// ST_LOAD   | accepting u-bits into u[idx], idx counts 0..N-1
// ST_XFORM  | one butterfly stage per enabled cycle, s counts 0..n-1
// ST_UNLOAD | presenting x[idx], idx advances on each transfer
module polar_encoder_core
    import polar_enc_pkg::*;
#(
    parameter int N_LOG2_MAX = N_LOG2_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             start,
    input  logic [STG_W-1:0] nLog2,
    input  logic             inValid,
    output logic             inReady,
    input  logic             inBit,
    input  logic             F,
    output logic             outValid,
    input  logic             outReady,
    output logic             outBit,
    output logic             outLast,
    output logic             busy,
    output logic             cfgErr
);

    localparam int NMAX = 1 << N_LOG2_MAX;
    localparam int IW   = N_LOG2_MAX;

    state_e            state_q;
    logic [STG_W-1:0]  nlog2_q;
    logic [IW-1:0]     idx_q;
    logic [STG_W-1:0]  stg_q;
    logic [NMAX-1:0]   u_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              out_bit_q;
    logic              out_last_q;
    logic              cfg_err_q;

    logic [NMAX-1:0]   u_xf_d;
    logic [IW:0]       n_m1_d;
    logic [IW-1:0]     idx_inc_d;
    logic              idx_at_end_d;
    logic              idx_inc_at_end_d;
    logic              in_acc_d;
    logic              out_xfer_d;

    polar_butterfly_stage #(
        .N_LOG2_MAX (N_LOG2_MAX)
    ) u_bfly (
        .u_i     (u_q),
        .s_i     (stg_q),
        .nlog2_i (nlog2_q),
        .v_o     (u_xf_d)
    );

    // N-1 is formed one bit wider than idx so that N = 2^N_LOG2_MAX does
    // not wrap to zero.
    assign n_m1_d           = ({{IW{1'b0}}, 1'b1} << nlog2_q) - 1'b1;
    assign idx_inc_d        = idx_q + 1'b1;
    assign idx_at_end_d     = ({1'b0, idx_q} == n_m1_d);
    assign idx_inc_at_end_d = ({1'b0, idx_inc_d} == n_m1_d);
    assign in_acc_d         = inValid & in_ready_q;
    assign out_xfer_d       = out_valid_q & outReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            nlog2_q     <= '0;
            idx_q       <= '0;
            stg_q       <= '0;
            u_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else if (enb) begin
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (nlog2_legal(nLog2, N_LOG2_MAX)) begin
                            nlog2_q    <= nLog2;
                            u_q        <= '0;
                            idx_q      <= '0;
                            stg_q      <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_acc_d) begin
                        u_q[idx_q] <= inBit & F;
                        if (idx_at_end_d) begin
                            in_ready_q <= 1'b0;
                            stg_q      <= '0;
                            state_q    <= ST_XFORM;
                        end else begin
                            idx_q <= idx_inc_d;
                        end
                    end
                end
                ST_XFORM: begin
                    u_q <= u_xf_d;
                    if (stg_q == nlog2_q - 1'b1) begin
                        // Present x_0 straight from the final stage output so
                        // that it is valid in the first UNLOAD cycle.
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_bit_q   <= u_xf_d[0];
                        out_last_q  <= (n_m1_d == '0);
                        state_q     <= ST_UNLOAD;
                    end else begin
                        stg_q <= stg_q + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_xfer_d) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_bit_q   <= 1'b0;
                            out_last_q  <= 1'b0;
                            idx_q       <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            idx_q      <= idx_inc_d;
                            out_bit_q  <= u_q[idx_inc_d];
                            out_last_q <= idx_inc_at_end_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign outBit   = out_bit_q;
    assign outLast  = out_last_q;
    assign busy     = (state_q != ST_IDLE);
    assign cfgErr   = cfg_err_q;

endmodule

// File: tb/tb_polar_encoder_core.sv
module tb_polar_encoder_core;

    localparam int NLM  = 10;
    localparam int NMAX = 1 << NLM;
    localparam int CYC_BUDGET = 20000;

    logic       clk;
    logic       reset;
    logic       enb;
    logic       start;
    logic [3:0] nLog2;
    logic       inValid;
    logic       inReady;
    logic       inBit;
    logic       F;
    logic       outValid;
    logic       outReady;
    logic       outBit;
    logic       outLast;
    logic       busy;
    logic       cfgErr;

    polar_encoder_core #(.N_LOG2_MAX(NLM)) dut (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .start    (start),
        .nLog2    (nLog2),
        .inValid  (inValid),
        .inReady  (inReady),
        .inBit    (inBit),
        .F        (F),
        .outValid (outValid),
        .outReady (outReady),
        .outBit   (outBit),
        .outLast  (outLast),
        .busy     (busy),
        .cfgErr   (cfgErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    bit tb_u  [NMAX];
    bit tb_f  [NMAX];
    bit got_x [NMAX];
    int got_n;
    int last_pos;
    int latency;
    int hold_err;
    int cfg_seen;
    bit timed_out;

    typedef struct {
        int         nl;
        logic [7:0] u;
        logic [7:0] f;
        logic [7:0] x;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x_k is the XOR of all effective u_i with k a bit-subset of i, which is
    // what the Kronecker power of [1 0;1 1] encodes.
    function automatic int model_mismatch(input int nl);
        int n;
        int mis;
        bit x;
        n   = 1 << nl;
        mis = 0;
        for (int k = 0; k < n; k++) begin
            x = 1'b0;
            for (int i = 0; i < n; i++)
                if ((i & k) == k) x ^= (tb_u[i] & tb_f[i]);
            if (x != got_x[k]) mis++;
        end
        return mis;
    endfunction

    task automatic run_block(input int nl, input bit gaps, input int abort_at);
        int n;
        int in_i;
        int cyc;
        int last_acc;
        int first_valid;
        bit prev_hold;
        logic pb;
        logic pl;
        n = 1 << nl;
        in_i = 0; cyc = 0; last_acc = -1; first_valid = -1;
        prev_hold = 1'b0; pb = 1'b0; pl = 1'b0;
        got_n = 0; last_pos = -1; hold_err = 0; cfg_seen = 0;
        @(negedge clk);
        enb = 1'b1; start = 1'b1; nLog2 = 4'(nl); inValid = 1'b0; outReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nLog2 = 4'($urandom_range(0, 15));
        while (got_n < n && got_n != abort_at && cyc < CYC_BUDGET) begin
            if (cfgErr) cfg_seen++;
            if (prev_hold && (outValid !== 1'b1 || outBit !== pb || outLast !== pl)) hold_err++;
            if (outValid && first_valid < 0) first_valid = cyc;
            enb = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (gaps) begin
                start = ($urandom_range(0, 7) == 0);
                nLog2 = 4'($urandom_range(0, 15));
            end
            inValid  = (in_i < n) && (!gaps || $urandom_range(0, 1) == 1);
            inBit    = (in_i < n) ? tb_u[in_i] : 1'b0;
            F        = (in_i < n) ? tb_f[in_i] : 1'b0;
            outReady = !gaps || ($urandom_range(0, 2) != 0);
            if (enb && inValid && inReady) begin
                last_acc = cyc;
                in_i++;
            end
            if (enb && outValid && outReady) begin
                got_x[got_n] = outBit;
                if (outLast) last_pos = got_n;
                got_n++;
            end
            prev_hold = outValid && !(enb && outReady);
            pb = outBit;
            pl = outLast;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; inValid = 1'b0; enb = 1'b1;
        timed_out = (cyc >= CYC_BUDGET);
        latency = (first_valid >= 0 && last_acc >= 0) ? first_valid - last_acc : -1;
    endtask

    task automatic check_idle_after(input string tag);
        int extra;
        extra = 0;
        chk({tag, "_idle"}, int'({busy, outValid, inReady}), 0);
        outReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (outValid) extra++;
        end
        chk({tag, "_extra_out"}, extra, 0);
    endtask

    task automatic apply_vec(input int i);
        int n;
        logic [7:0] g;
        n = 1 << tbl[i].nl;
        for (int k = 0; k < NMAX; k++) begin
            tb_u[k] = 1'b0;
            tb_f[k] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            tb_u[k] = tbl[i].u[k];
            tb_f[k] = tbl[i].f[k];
        end
        run_block(tbl[i].nl, 1'b0, -1);
        g = '0;
        for (int k = 0; k < n; k++) g[k] = got_x[k];
        chk($sformatf("vec%0d_timeout", i), int'(timed_out), 0);
        chk($sformatf("vec%0d_x", i), int'(g), int'(tbl[i].x));
        chk($sformatf("vec%0d_last", i), last_pos, n - 1);
        chk($sformatf("vec%0d_latency", i), latency, tbl[i].nl + 1);
        check_idle_after($sformatf("vec%0d", i));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nl;

        tbl[0] = '{nl: 3, u: 8'h01, f: 8'hFF, x: 8'h01};
        tbl[1] = '{nl: 3, u: 8'h08, f: 8'hFF, x: 8'h0F};
        tbl[2] = '{nl: 3, u: 8'h80, f: 8'hFF, x: 8'hFF};
        tbl[3] = '{nl: 3, u: 8'hFF, f: 8'hE8, x: 8'h96};
        tbl[4] = '{nl: 1, u: 8'h03, f: 8'h03, x: 8'h02};

        reset = 1'b1; enb = 1'b1; start = 1'b0; nLog2 = '0;
        inValid = 1'b0; inBit = 1'b0; F = 1'b0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({inReady, outValid, outBit, outLast, busy, cfgErr}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Illegal block sizes: single cfgErr pulse, FSM stays idle.
        for (int v = 0; v < 2; v++) begin
            start = 1'b1;
            nLog2 = (v == 0) ? 4'd0 : 4'(NLM + 1);
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("cfgerr%0d_pulse", v), int'(cfgErr), 1);
            chk($sformatf("cfgerr%0d_busy", v), int'(busy), 0);
            @(negedge clk);
            chk($sformatf("cfgerr%0d_clear", v), int'({cfgErr, busy}), 0);
        end

        for (int i = 0; i < 4; i++) apply_vec(i);

        // Abort in the middle of UNLOAD with x_3 on the output.
        for (int k = 0; k < NMAX; k++) begin
            tb_u[k] = 1'b1;
            tb_f[k] = 1'b1;
        end
        run_block(3, 1'b0, 3);
        chk("abort_reached_idx3", got_n, 3);
        chk("abort_valid_before", int'(outValid), 1);
        outReady = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outvalid", int'(outValid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_inready", int'(inReady), 0);
        reset = 1'b0;
        apply_vec(4);

        // Randomized blocks with input/output/enable gaps and stray starts.
        for (int b = 0; b < 5; b++) begin
            nl = (b < 2) ? NLM : int'($urandom_range(1, NLM - 1));
            n  = 1 << nl;
            for (int k = 0; k < NMAX; k++) begin
                tb_u[k] = 1'($urandom_range(0, 1));
                tb_f[k] = 1'($urandom_range(0, 1));
            end
            run_block(nl, 1'b1, -1);
            chk($sformatf("rnd%0d_timeout", b), int'(timed_out), 0);
            chk($sformatf("rnd%0d_count", b), got_n, n);
            chk($sformatf("rnd%0d_last", b), last_pos, n - 1);
            chk($sformatf("rnd%0d_hold", b), hold_err, 0);
            chk($sformatf("rnd%0d_cfgerr", b), cfg_seen, 0);
            chk($sformatf("rnd%0d_x_mismatch", b), model_mismatch(nl), 0);
            check_idle_after($sformatf("rnd%0d", b));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
